// File: rtl/calendar_date_counter.sv
// Day/month/year calendar counter with Gregorian leap handling, manual field edits and a
// parallel load followed by a multi-cycle resync of the leap-year mod counters.
module calendar_date_counter #(
    parameter int unsigned YEAR_W    = 14,
    parameter int unsigned YEAR_MIN  = 0,
    parameter int unsigned YEAR_MAX  = 9999,
    parameter int unsigned RST_YEAR  = 2024,
    parameter int unsigned RST_MONTH = 1,
    parameter int unsigned RST_DAY   = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              day_tick_i,
    input  logic              inc_manual_i,
    input  logic              dec_manual_i,
    input  logic [1:0]        field_sel_i,
    input  logic              load_i,
    input  logic [YEAR_W-1:0] load_year_i,
    input  logic [3:0]        load_month_i,
    input  logic [4:0]        load_day_i,
    output logic [YEAR_W-1:0] year_o,
    output logic [3:0]        month_o,
    output logic [4:0]        day_o,
    output logic              leap_o,
    output logic [4:0]        dim_o,
    output logic              year_wrap_o,
    output logic              busy_o,
    output logic              load_err_o
);

    localparam logic [YEAR_W-1:0] YearMin  = YEAR_W'(YEAR_MIN);
    localparam logic [YEAR_W-1:0] YearMax  = YEAR_W'(YEAR_MAX);
    localparam logic [YEAR_W-1:0] RstYear  = YEAR_W'(RST_YEAR);
    localparam logic [YEAR_W-1:0] Sub400   = YEAR_W'(400);
    localparam logic [YEAR_W-1:0] Sub100   = YEAR_W'(100);
    localparam logic [1:0] MinMod4   = 2'(YEAR_MIN % 4);
    localparam logic [6:0] MinMod100 = 7'(YEAR_MIN % 100);
    localparam logic [8:0] MinMod400 = 9'(YEAR_MIN % 400);
    localparam logic [1:0] MaxMod4   = 2'(YEAR_MAX % 4);
    localparam logic [6:0] MaxMod100 = 7'(YEAR_MAX % 100);
    localparam logic [8:0] MaxMod400 = 9'(YEAR_MAX % 400);
    localparam logic [1:0] RstMod4   = 2'(RST_YEAR % 4);
    localparam logic [6:0] RstMod100 = 7'(RST_YEAR % 100);
    localparam logic [8:0] RstMod400 = 9'(RST_YEAR % 400);

    typedef enum logic [1:0] {StIdle, StR400, StR100} state_e;

    state_e            state_q;
    logic [YEAR_W-1:0] year_q, r_q;
    logic [3:0]        month_q;
    logic [4:0]        day_q;
    logic [1:0]        mod4_q;
    logic [6:0]        mod100_q;
    logic [8:0]        mod400_q;
    logic              pend_q, year_wrap_q, load_err_q;

    logic              leap_cur, tick, man_inc, man_dec, man_year_leap, exit_leap;
    logic [YEAR_W-1:0] yinc_year, ydec_year;
    logic [1:0]        yinc_m4, ydec_m4;
    logic [6:0]        yinc_m100, ydec_m100;
    logic [8:0]        yinc_m400, ydec_m400;
    logic              yinc_wrap, ydec_wrap, yinc_leap, ydec_leap;
    logic [3:0]        man_month;
    logic [4:0]        man_dim, man_day, ld_dim;
    logic              year_lo_ok, load_ok;

    function automatic logic [4:0] dim_of(input logic [3:0] m, input logic lp);
        unique case (m)
            4'd2:                      dim_of = lp ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   dim_of = 5'd30;
            default:                   dim_of = 5'd31;
        endcase
    endfunction

    // A zero lower bound makes the comparison trivially true; keep it out of the netlist.
    if (YEAR_MIN == 0) begin : g_min_zero
        assign year_lo_ok = 1'b1;
    end else begin : g_min_cmp
        assign year_lo_ok = (load_year_i >= YearMin);
    end

    always_comb begin
        leap_cur = ((mod4_q == 2'd0) && (mod100_q != 7'd0)) || (mod400_q == 9'd0);
        leap_o   = (state_q == StIdle) && leap_cur;
        dim_o    = dim_of(month_q, leap_o);
        tick     = day_tick_i | pend_q;
        man_inc  = inc_manual_i & ~dec_manual_i;
        man_dec  = dec_manual_i & ~inc_manual_i;

        if (year_q == YearMax) begin
            yinc_year = YearMin;
            yinc_m4   = MinMod4;
            yinc_m100 = MinMod100;
            yinc_m400 = MinMod400;
            yinc_wrap = 1'b1;
        end else begin
            yinc_year = year_q + YEAR_W'(1);
            yinc_m4   = mod4_q + 2'd1;
            yinc_m100 = (mod100_q == 7'd99) ? 7'd0 : mod100_q + 7'd1;
            yinc_m400 = (mod400_q == 9'd399) ? 9'd0 : mod400_q + 9'd1;
            yinc_wrap = 1'b0;
        end
        if (year_q == YearMin) begin
            ydec_year = YearMax;
            ydec_m4   = MaxMod4;
            ydec_m100 = MaxMod100;
            ydec_m400 = MaxMod400;
            ydec_wrap = 1'b1;
        end else begin
            ydec_year = year_q - YEAR_W'(1);
            ydec_m4   = mod4_q - 2'd1;
            ydec_m100 = (mod100_q == 7'd0) ? 7'd99 : mod100_q - 7'd1;
            ydec_m400 = (mod400_q == 9'd0) ? 9'd399 : mod400_q - 9'd1;
            ydec_wrap = 1'b0;
        end
        yinc_leap     = ((yinc_m4 == 2'd0) && (yinc_m100 != 7'd0)) || (yinc_m400 == 9'd0);
        ydec_leap     = ((ydec_m4 == 2'd0) && (ydec_m100 != 7'd0)) || (ydec_m400 == 9'd0);
        man_year_leap = man_inc ? yinc_leap : ydec_leap;

        if (man_inc) man_month = (month_q == 4'd12) ? 4'd1 : month_q + 4'd1;
        else         man_month = (month_q == 4'd1) ? 4'd12 : month_q - 4'd1;
        man_dim = dim_of(man_month, leap_o);
        if (man_inc) man_day = (day_q >= dim_o) ? 5'd1 : day_q + 5'd1;
        else         man_day = (day_q <= 5'd1) ? dim_o : day_q - 5'd1;

        // r_q holds year % 100 on the R100 exit cycle; mod400_q is already final.
        exit_leap = ((r_q[1:0] == 2'd0) && (r_q[6:0] != 7'd0)) || (mod400_q == 9'd0);

        // Feb accepts 29 here; the resync exit trims it for non-leap years.
        ld_dim  = dim_of(load_month_i, 1'b1);
        load_ok = year_lo_ok && (load_year_i <= YearMax) &&
                  (load_month_i >= 4'd1) && (load_month_i <= 4'd12) &&
                  (load_day_i != 5'd0) && (load_day_i <= ld_dim);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            year_q      <= RstYear;
            month_q     <= 4'(RST_MONTH);
            day_q       <= 5'(RST_DAY);
            mod4_q      <= RstMod4;
            mod100_q    <= RstMod100;
            mod400_q    <= RstMod400;
            r_q         <= '0;
            pend_q      <= 1'b0;
            year_wrap_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            year_wrap_q <= 1'b0;
            load_err_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    pend_q <= 1'b0;
                    if (load_i) begin
                        if (load_ok) begin
                            year_q  <= load_year_i;
                            month_q <= load_month_i;
                            day_q   <= load_day_i;
                            r_q     <= load_year_i;
                            state_q <= StR400;
                        end else begin
                            load_err_q <= 1'b1;
                        end
                    end else if (tick) begin
                        if (day_q < dim_o) begin
                            day_q <= day_q + 5'd1;
                        end else begin
                            day_q <= 5'd1;
                            if (month_q == 4'd12) begin
                                month_q     <= 4'd1;
                                year_q      <= yinc_year;
                                mod4_q      <= yinc_m4;
                                mod100_q    <= yinc_m100;
                                mod400_q    <= yinc_m400;
                                year_wrap_q <= yinc_wrap;
                            end else begin
                                month_q <= month_q + 4'd1;
                            end
                        end
                    end else if (man_inc || man_dec) begin
                        unique case (field_sel_i)
                            2'd0: day_q <= man_day;
                            2'd1: begin
                                month_q <= man_month;
                                if (day_q > man_dim) day_q <= man_dim;
                            end
                            2'd2: begin
                                year_q      <= man_inc ? yinc_year : ydec_year;
                                mod4_q      <= man_inc ? yinc_m4 : ydec_m4;
                                mod100_q    <= man_inc ? yinc_m100 : ydec_m100;
                                mod400_q    <= man_inc ? yinc_m400 : ydec_m400;
                                year_wrap_q <= man_inc ? yinc_wrap : ydec_wrap;
                                if (month_q == 4'd2 && day_q == 5'd29 && !man_year_leap) begin
                                    day_q <= 5'd28;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                StR400: begin
                    if (day_tick_i) pend_q <= 1'b1;
                    if (r_q >= Sub400) begin
                        r_q <= r_q - Sub400;
                    end else begin
                        mod400_q <= r_q[8:0];
                        state_q  <= StR100;
                    end
                end
                StR100: begin
                    if (day_tick_i) pend_q <= 1'b1;
                    if (r_q >= Sub100) begin
                        r_q <= r_q - Sub100;
                    end else begin
                        mod100_q <= r_q[6:0];
                        mod4_q   <= r_q[1:0];
                        state_q  <= StIdle;
                        if (month_q == 4'd2 && day_q == 5'd29 && !exit_leap) day_q <= 5'd28;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign year_o      = year_q;
    assign month_o     = month_q;
    assign day_o       = day_q;
    assign year_wrap_o = year_wrap_q;
    assign load_err_o  = load_err_q;
    assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_calendar_date_counter.sv
// Directed bench for calendar_date_counter: leap days, resync timing, wrap, manual edits,
// load rejection, tick latching while busy and reset during resync.
module tb_calendar_date_counter;
    localparam int YW = 14;

    logic          clk = 1'b0;
    logic          rst, day_tick, inc_manual, dec_manual, load;
    logic [1:0]    field_sel;
    logic [YW-1:0] load_year, year;
    logic [3:0]    load_month, month;
    logic [4:0]    load_day, day, dim;
    logic          leap, year_wrap, busy, load_err;

    int tests = 0;
    int fails = 0;
    int n;

    always #5 clk = ~clk;

    calendar_date_counter #(
        .YEAR_W(YW), .YEAR_MIN(0), .YEAR_MAX(9999),
        .RST_YEAR(2024), .RST_MONTH(1), .RST_DAY(1)
    ) dut (
        .clk_i(clk), .rst_i(rst), .day_tick_i(day_tick),
        .inc_manual_i(inc_manual), .dec_manual_i(dec_manual), .field_sel_i(field_sel),
        .load_i(load), .load_year_i(load_year), .load_month_i(load_month),
        .load_day_i(load_day), .year_o(year), .month_o(month), .day_o(day),
        .leap_o(leap), .dim_o(dim), .year_wrap_o(year_wrap), .busy_o(busy),
        .load_err_o(load_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_date(input string tag, input int y, input int m, input int d);
        check({tag, "_year"}, 32'(year), y);
        check({tag, "_month"}, 32'(month), m);
        check({tag, "_day"}, 32'(day), d);
    endtask

    task automatic do_load(input int y, input int m, input int d);
        load = 1'b1;
        load_year = YW'(y);
        load_month = 4'(m);
        load_day = 5'(d);
        step();
        load = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 200) begin
            step();
            k++;
        end
        check("idle_bound", 32'(busy), 0);
    endtask

    task automatic tick_once();
        day_tick = 1'b1;
        step();
        day_tick = 1'b0;
    endtask

    initial begin
        rst = 1'b1; day_tick = 1'b0; inc_manual = 1'b0; dec_manual = 1'b0;
        field_sel = 2'd3; load = 1'b0; load_year = '0; load_month = '0; load_day = '0;
        step();
        step();
        rst = 1'b0;
        check_date("reset", 2024, 1, 1);
        check("reset_busy", 32'(busy), 0);
        check("reset_leap", 32'(leap), 1);
        check("reset_dim", 32'(dim), 31);
        check("reset_wrap", 32'(year_wrap), 0);
        check("reset_err", 32'(load_err), 0);

        // Leap day rollover in 2024
        do_load(2024, 2, 28);
        check("load_busy", 32'(busy), 1);
        wait_idle();
        check_date("feb28", 2024, 2, 28);
        check("feb28_dim", 32'(dim), 29);
        tick_once();
        check_date("feb29", 2024, 2, 29);
        check("feb29_leap", 32'(leap), 1);
        tick_once();
        check_date("mar01", 2024, 3, 1);
        check("mar01_dim", 32'(dim), 31);

        // 1900 is not leap: 9 busy cycles, Feb 29 trimmed
        do_load(1900, 2, 29);
        n = 0;
        while (busy && n < 100) begin
            n++;
            step();
        end
        check("busy_cycles_1900", n, 9);
        check_date("y1900", 1900, 2, 28);
        check("y1900_leap", 32'(leap), 0);
        check("y1900_dim", 32'(dim), 28);

        do_load(2000, 2, 29);
        n = 0;
        while (busy && n < 100) begin
            n++;
            step();
        end
        check("busy_cycles_2000", n, 7);
        check_date("y2000", 2000, 2, 29);
        check("y2000_leap", 32'(leap), 1);

        // Top-of-range wrap
        do_load(9999, 12, 31);
        wait_idle();
        check("y9999_leap", 32'(leap), 0);
        tick_once();
        check_date("wrap", 0, 1, 1);
        check("wrap_pulse", 32'(year_wrap), 1);
        check("y0_leap", 32'(leap), 1);
        step();
        check("wrap_pulse_end", 32'(year_wrap), 0);

        // Manual month edits clamp the day and never touch the year
        do_load(2023, 3, 31);
        wait_idle();
        field_sel = 2'd1;
        dec_manual = 1'b1;
        step();
        dec_manual = 1'b0;
        check_date("man_dec_month", 2023, 2, 28);
        inc_manual = 1'b1;
        for (int i = 0; i < 11; i++) step();
        inc_manual = 1'b0;
        check_date("man_inc_month", 2023, 1, 28);
        inc_manual = 1'b1;
        dec_manual = 1'b1;
        step();
        inc_manual = 1'b0;
        dec_manual = 1'b0;
        check_date("man_both_noop", 2023, 1, 28);
        field_sel = 2'd0;
        dec_manual = 1'b1;
        step();
        dec_manual = 1'b0;
        check_date("man_dec_day", 2023, 1, 27);

        // Manual year off a leap day
        do_load(2024, 2, 29);
        wait_idle();
        field_sel = 2'd2;
        inc_manual = 1'b1;
        step();
        inc_manual = 1'b0;
        field_sel = 2'd3;
        check_date("man_year", 2025, 2, 28);
        check("man_year_leap", 32'(leap), 0);

        // Rejected loads
        do_load(2024, 13, 1);
        check("err_month13", 32'(load_err), 1);
        check("err_month13_busy", 32'(busy), 0);
        check_date("err_month13", 2025, 2, 28);
        step();
        check("err_pulse_end", 32'(load_err), 0);
        do_load(2024, 4, 31);
        check("err_apr31", 32'(load_err), 1);
        check_date("err_apr31", 2025, 2, 28);
        do_load(10000, 1, 1);
        check("err_year_range", 32'(load_err), 1);

        // Three ticks while busy -> one advance
        do_load(2024, 5, 10);
        tick_once();
        step();
        tick_once();
        tick_once();
        check("pend_still_busy", 32'(busy), 1);
        wait_idle();
        step();
        check_date("pend_one", 2024, 5, 11);
        step();
        step();
        check_date("pend_once_only", 2024, 5, 11);

        // Reset in the middle of a resync
        do_load(9999, 6, 15);
        step();
        step();
        check("mid_busy", 32'(busy), 1);
        day_tick = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        day_tick = 1'b0;
        check_date("mid_reset", 2024, 1, 1);
        check("mid_reset_busy", 32'(busy), 0);
        check("mid_reset_leap", 32'(leap), 1);
        step();
        check_date("mid_reset_nopend", 2024, 1, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
